// File: rtl/ifu_if.sv
// ifu_if -- bundle of every signal between the instruction fetch unit and its
// neighbours.
//   Instruction memory: imem_req / imem_addr out, imem_gnt / imem_rvalid / imem_rdata in
//   Redirect from execute: redirect / redirect_pc in
//   Decode handoff: id_valid / id_inst / id_pc out, id_ready in
//   Status: misalign out
// Modports: master = the fetch unit, slave = memory, execute and decode side.
interface ifu_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        misalign;

  modport master (
    output imem_req, imem_addr, id_valid, id_inst, id_pc, misalign,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_inst, id_pc, misalign,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/ifu.sv
// ifu -- instruction fetch unit with a two-entry instruction queue.
// Issues at most one outstanding fetch at a time, buffers returned
// instructions with their addresses and presents the oldest one to decode.
// Ports:
//   clk   single clock, rising edge
//   rstn  asynchronous active-low reset
//   bus   ifu_if.master (instruction memory, redirect, decode and status signals)
// Parameter:
//   RESET_PC  first fetch address after reset
// Optional build macro:
//   IFU_MISALIGN_CHK_EN  when defined, a redirect to a non word-aligned target
//   flushes, raises misalign and halts fetching until an aligned redirect.
//   When undefined the low two target bits are dropped and misalign is 0.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic  clk,
  input  logic  rstn,
  ifu_if.master bus
);

  // One-hot so imem_req is a single state flop rather than decode logic.
  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_REQ  = 4'b0010,
    S_WAIT = 4'b0100,
    S_HALT = 4'b1000
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;       // next address to request
  logic [31:0] r_fpc;      // address of the fetch currently outstanding
  logic [1:0]  r_cnt;      // queue occupancy 0..2
  logic        r_discard;  // drop the next response (it belongs to a stale path)
  logic [31:0] r_q_inst [2];
  logic [31:0] r_q_pc   [2];

  logic        w_pop;
  logic        w_push;
  logic [1:0]  w_wr_idx;
  logic [1:0]  w_cnt_nxt;
  logic        w_out_nxt;
  logic [31:0] w_tgt;
  logic        w_bad;

  // Redirect wins over a same-cycle pop or push: the queue is flushed anyway.
  assign w_pop     = (r_cnt != 2'd0) && bus.id_ready && !bus.redirect;
  assign w_wr_idx  = r_cnt - {1'b0, w_pop};
  assign w_push    = (r_state == S_WAIT) && bus.imem_rvalid && !r_discard &&
                     !bus.redirect && (w_wr_idx != 2'd2);
  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

  // A fetch is still in flight after this edge if it was granted now, or it
  // was already pending and no response arrived this cycle.
  assign w_out_nxt = ((r_state == S_REQ)  && bus.imem_gnt) ||
                     ((r_state == S_WAIT) && !bus.imem_rvalid) ||
                     ((r_state == S_HALT) && r_discard && !bus.imem_rvalid);

`ifdef IFU_MISALIGN_CHK_EN
  logic r_misalign;

  assign w_tgt = bus.redirect_pc;
  assign w_bad = (bus.redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_misalign <= 1'b0;
    end else if (bus.redirect) begin
      r_misalign <= w_bad;
    end
  end

  assign bus.misalign = r_misalign;
`else
  logic w_unused_tgt_lsb;

  assign w_tgt            = {bus.redirect_pc[31:2], 2'b00};
  assign w_bad            = 1'b0;
  assign w_unused_tgt_lsb = ^bus.redirect_pc[1:0];
  assign bus.misalign     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_fpc       <= RESET_PC;
      r_cnt       <= 2'd0;
      r_discard   <= 1'b0;
      r_q_inst[0] <= 32'h0;
      r_q_inst[1] <= 32'h0;
      r_q_pc[0]   <= 32'h0;
      r_q_pc[1]   <= 32'h0;
    end else begin
      // Head is always entry 0; a pop shifts entry 1 down. A same-cycle push
      // lands in the slot freed by the pop (later assignment wins).
      if (w_pop) begin
        r_q_inst[0] <= r_q_inst[1];
        r_q_pc[0]   <= r_q_pc[1];
      end
      if (w_push) begin
        r_q_inst[w_wr_idx[0]] <= bus.imem_rdata;
        r_q_pc[w_wr_idx[0]]   <= r_fpc;
      end

      if (bus.redirect) begin
        r_cnt     <= 2'd0;
        r_discard <= w_out_nxt;
        if (w_bad) begin
          r_state <= S_HALT;
        end else begin
          r_pc    <= w_tgt;
          r_state <= w_out_nxt ? S_WAIT : S_REQ;
        end
      end else begin
        r_cnt <= w_cnt_nxt;
        case (r_state)
          S_IDLE: begin
            if (r_cnt != 2'd2) r_state <= S_REQ;
          end
          S_REQ: begin
            if (bus.imem_gnt) begin
              r_fpc   <= r_pc;
              r_pc    <= r_pc + 32'd4;
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (bus.imem_rvalid) begin
              r_discard <= 1'b0;
              r_state   <= (w_cnt_nxt != 2'd2) ? S_REQ : S_IDLE;
            end
          end
          S_HALT: begin
            // A response to a fetch abandoned on entry here simply drains.
            if (bus.imem_rvalid) r_discard <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.imem_req  = (r_state == S_REQ);
  assign bus.imem_addr = r_pc;
  assign bus.id_valid  = (r_cnt != 2'd0);
  assign bus.id_inst   = r_q_inst[0];
  assign bus.id_pc     = r_q_pc[0];

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;
  logic clk;
  logic rstn;
  logic gnt_en;
  int   n_cmp;
  int   n_bad;
  logic [31:0] b_pc_log [$];
  logic [31:0] b_in_log [$];
  logic [31:0] w_pc_log [$];

  ifu_if b ();
  ifu_if w ();

  ifu #(.RESET_PC(32'h0000_0000)) dut   (.clk(clk), .rstn(rstn), .bus(b));
  ifu #(.RESET_PC(32'hFFFF_FFF8)) dut_w (.clk(clk), .rstn(rstn), .bus(w));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle. Before the edge, record pops and grants seen in the
  // current cycle; at the next negedge play a 1-cycle memory (data = ~addr).
  task automatic cyc();
    logic        bp, wp;
    logic [31:0] bd, wd;
    if (b.id_valid && b.id_ready && !b.redirect) begin
      b_pc_log.push_back(b.id_pc);
      b_in_log.push_back(b.id_inst);
    end
    if (w.id_valid && w.id_ready) w_pc_log.push_back(w.id_pc);
    bp = b.imem_req && b.imem_gnt;
    bd = ~b.imem_addr;
    wp = w.imem_req && w.imem_gnt;
    wd = ~w.imem_addr;
    @(negedge clk);
    b.imem_rvalid = bp;
    b.imem_rdata  = bp ? bd : 32'h0;
    b.imem_gnt    = gnt_en;
    b.redirect    = 1'b0;
    w.imem_rvalid = wp;
    w.imem_rdata  = wp ? wd : 32'h0;
    w.imem_gnt    = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    cyc();
    cyc();
    rstn = 1'b1;
    b_pc_log.delete();
    b_in_log.delete();
  endtask

  task automatic wait_log(input int want, input int budget);
    for (int k = 0; k < budget && b_pc_log.size() < want; k++) cyc();
    chk("log_len", 32'(b_pc_log.size()), 32'(want));
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    rstn          = 1'b0;
    gnt_en        = 1'b1;
    b.imem_gnt    = 1'b0;
    b.imem_rvalid = 1'b0;
    b.imem_rdata  = 32'h0;
    b.redirect    = 1'b0;
    b.redirect_pc = 32'h0;
    b.id_ready    = 1'b1;
    w.imem_gnt    = 1'b0;
    w.imem_rvalid = 1'b0;
    w.imem_rdata  = 32'h0;
    w.redirect    = 1'b0;
    w.redirect_pc = 32'h0;
    w.id_ready    = 1'b1;

    // Reset values, then streaming with 1-cycle memory and id_ready=1
    cyc();
    cyc();
    chk("rst_req",      32'(b.imem_req), 32'd0);
    chk("rst_addr",     b.imem_addr,     32'h0);
    chk("rst_valid",    32'(b.id_valid), 32'd0);
    chk("rst_inst",     b.id_inst,       32'h0);
    chk("rst_pc",       b.id_pc,         32'h0);
    chk("rst_misalign", 32'(b.misalign), 32'd0);
    chk("rst_addr_w",   w.imem_addr,     32'hFFFF_FFF8);
    rstn = 1'b1;
    cyc();
    chk("first_req",  32'(b.imem_req), 32'd1);
    chk("first_addr", b.imem_addr,     32'h0);
    cyc();
    chk("lat_valid_n1", 32'(b.id_valid), 32'd0);
    cyc();
    chk("lat_valid_n2", 32'(b.id_valid), 32'd1);
    chk("lat_pc",       b.id_pc,         32'h0);
    chk("lat_inst",     b.id_inst,       32'hFFFF_FFFF);
    for (int k = 0; k < 40 && (b_pc_log.size() < 4 || w_pc_log.size() < 4); k++) cyc();
    chk("seq_len",   32'(b_pc_log.size()), 32'd4);
    chk("seq_pc0",   b_pc_log[0], 32'h0);
    chk("seq_pc1",   b_pc_log[1], 32'h4);
    chk("seq_pc2",   b_pc_log[2], 32'h8);
    chk("seq_pc3",   b_pc_log[3], 32'hC);
    chk("seq_inst3", b_in_log[3], 32'hFFFF_FFF3);
    chk("wrap_len",  32'(w_pc_log.size()), 32'd4);
    chk("wrap_pc0",  w_pc_log[0], 32'hFFFF_FFF8);
    chk("wrap_pc1",  w_pc_log[1], 32'hFFFF_FFFC);
    chk("wrap_pc2",  w_pc_log[2], 32'h0);
    chk("wrap_pc3",  w_pc_log[3], 32'h4);

    // Decode stalled for 10 cycles: queue fills to 2 and fetching stops
    b.id_ready = 1'b0;
    do_reset();
    repeat (10) cyc();
    chk("stall_req",   32'(b.imem_req), 32'd0);
    chk("stall_valid", 32'(b.id_valid), 32'd1);
    chk("stall_pc",    b.id_pc,         32'h0);
    chk("stall_inst",  b.id_inst,       32'hFFFF_FFFF);
    chk("stall_addr",  b.imem_addr,     32'h8);
    b.id_ready = 1'b1;
    wait_log(3, 40);
    chk("drain_pc0", b_pc_log[0], 32'h0);
    chk("drain_pc1", b_pc_log[1], 32'h4);
    chk("drain_pc2", b_pc_log[2], 32'h8);

    // Redirect while waiting on pc 8; its response arrives a cycle late
    do_reset();
    repeat (6) cyc();
    chk("wait8_addr", b.imem_addr,     32'hC);
    chk("wait8_req",  32'(b.imem_req), 32'd0);
    b_pc_log.delete();
    b_in_log.delete();
    b.imem_rvalid = 1'b0;
    b.redirect    = 1'b1;
    b.redirect_pc = 32'h100;
    cyc();
    chk("redir_valid", 32'(b.id_valid), 32'd0);
    chk("redir_req",   32'(b.imem_req), 32'd0);
    b.imem_rvalid = 1'b1;
    b.imem_rdata  = 32'hFFFF_FFF7;
    cyc();
    chk("drop_valid", 32'(b.id_valid), 32'd0);
    chk("drop_req",   32'(b.imem_req), 32'd1);
    chk("drop_addr",  b.imem_addr,     32'h100);
    wait_log(2, 40);
    chk("redir_pc0",   b_pc_log[0], 32'h100);
    chk("redir_pc1",   b_pc_log[1], 32'h104);
    chk("redir_inst0", b_in_log[0], 32'hFFFF_FEFF);

    // Grant withheld: address must hold, redirect replaces it next cycle
    gnt_en = 1'b0;
    do_reset();
    cyc();
    chk("nognt_req1",  32'(b.imem_req), 32'd1);
    chk("nognt_addr1", b.imem_addr,     32'h0);
    cyc();
    chk("nognt_addr2", b.imem_addr,     32'h0);
    cyc();
    chk("nognt_addr3", b.imem_addr,     32'h0);
    b.redirect    = 1'b1;
    b.redirect_pc = 32'h40;
    cyc();
    chk("nognt_req4",  32'(b.imem_req), 32'd1);
    chk("nognt_addr4", b.imem_addr,     32'h40);
    cyc();
    chk("nognt_addr5", b.imem_addr,     32'h40);
    gnt_en = 1'b1;
    wait_log(1, 20);
    chk("nognt_pc",   b_pc_log[0], 32'h40);
    chk("nognt_inst", b_in_log[0], 32'hFFFF_FFBF);

    // Redirect to 0x102 in the same cycle as a grant
    do_reset();
    repeat (3) cyc();
    chk("mis_pre_addr", b.imem_addr,     32'h4);
    chk("mis_pre_req",  32'(b.imem_req), 32'd1);
    b_pc_log.delete();
    b_in_log.delete();
    b.redirect    = 1'b1;
    b.redirect_pc = 32'h102;
    cyc();
`ifdef IFU_MISALIGN_CHK_EN
    chk("mis_flag",  32'(b.misalign), 32'd1);
    chk("mis_req",   32'(b.imem_req), 32'd0);
    chk("mis_valid", 32'(b.id_valid), 32'd0);
    repeat (3) cyc();
    chk("halt_req",  32'(b.imem_req), 32'd0);
    chk("halt_flag", 32'(b.misalign), 32'd1);
    b.redirect    = 1'b1;
    b.redirect_pc = 32'h200;
    cyc();
    chk("resume_flag", 32'(b.misalign), 32'd0);
    chk("resume_req",  32'(b.imem_req), 32'd1);
    chk("resume_addr", b.imem_addr,     32'h200);
    wait_log(1, 20);
    chk("resume_pc", b_pc_log[0], 32'h200);
`else
    chk("mis_flag",  32'(b.misalign), 32'd0);
    chk("mis_req",   32'(b.imem_req), 32'd0);
    chk("mis_valid", 32'(b.id_valid), 32'd0);
    cyc();
    chk("mis_req2",  32'(b.imem_req), 32'd1);
    chk("mis_addr2", b.imem_addr,     32'h100);
    wait_log(1, 20);
    chk("mis_pc",   b_pc_log[0], 32'h100);
    chk("mis_inst", b_in_log[0], 32'hFFFF_FEFF);
`endif

    // Reset while a fetch is outstanding, late response after release
    do_reset();
    cyc();
    cyc();
    chk("mid_req_wait", 32'(b.imem_req), 32'd0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_addr",  b.imem_addr,     32'h0);
    chk("mid_rst_valid", 32'(b.id_valid), 32'd0);
    cyc();
    rstn          = 1'b1;
    b.imem_rvalid = 1'b1;
    b.imem_rdata  = 32'hDEAD_BEEF;
    cyc();
    chk("late_valid", 32'(b.id_valid), 32'd0);
    chk("late_req",   32'(b.imem_req), 32'd1);
    chk("late_addr",  b.imem_addr,     32'h0);
    wait_log(1, 20);
    chk("late_pc",   b_pc_log[0], 32'h0);
    chk("late_inst", b_in_log[0], 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
